multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multicycle RV32I datapath, sequencing one instruction over several clock cycles on a shared ALU and a unified instruction/data memory. It sits beside the datapath and drives every mux select and write enable. It supports lw, sw, R-type, I-type ALU, beq and jal. Memory accesses hold on a ready handshake, and the block counts retired instructions.

## Interface
Parameters
- CNT_W, 32, width of the retired-instruction counter

Ports
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- op  input  7  opcode field of the instruction register
- zero  input  1  ALU zero flag
- memReady  input  1  memory completes the current access this cycle
- pcWrite  output  1  PC register enable
- adrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- memWrite  output  1  memory write strobe
- irWrite  output  1  instruction/oldPC register enable
- regWrite  output  1  register file write enable
- resultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- aluSrcA  output  2  SrcA: 00=PC, 01=OldPC, 10=RD1
- aluSrcB  output  2  SrcB: 00=WD (RD2), 01=ImmExt, 10=constant 4
- aluOp  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
- immSrc  output  2  extender select
- illegal  output  1  illegal-opcode flag
- state  output  4  current state encoding, for debug
- instret  output  CNT_W  retired-instruction count

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
- All outputs are combinational from state. pcWrite = pcUpdate | (branch & zero). Signals not listed for a state are 0.
- FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - irWrite=pcUpdate=memReady.
  - Stays in FETCH while memReady=0; moves to DECODE when memReady=1.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> illegal handling (see Configuration)
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: adrSrc=1, resultSrc=00. Waits on memReady, then goes to MEMWB.
- MEMWB: resultSrc=01, regWrite=1, then FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1. memWrite stays high until memReady=1, then FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10, then ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10, then ALUWB.
- ALUWB: resultSrc=00, regWrite=1, then FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1, then ALUWB.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, then FETCH.
- immSrc decodes combinationally from op:
  - lw, I-type, R-type, unknown -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - Outputs are never x.
- instret increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W.

## Timing
- While rst_n=0: state=FETCH and instret=0. pcWrite, irWrite, regWrite, memWrite and illegal are forced to 0. Selects hold their FETCH values.
- Reset asserted mid-instruction aborts the instruction immediately; the count is not incremented.
- After rst_n deasserts, the first edge with memReady=1 fetches.
- Cycles per instruction, with memReady held at 1:
  - lw 5
  - sw, R-type, I-type, jal 4
  - beq 3
- Each cycle with memReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- memReady is ignored in all other states.
- The zero flag is sampled combinationally during BEQ only.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unknown op in DECODE goes to TRAP.
  - TRAP asserts illegal=1, all enables are 0, and the FSM stays in TRAP until reset.
- Not defined:
  - An unknown op in DECODE returns to FETCH with no writes and no instret increment. This skips the instruction.
  - illegal is tied to 0 and TRAP is unreachable.

## Test plan
- Reset: rst_n=0 mid-EXECUTER -> state=0, instret=0, all enables 0 at once.
- lw with memReady=1 -> states 0,1,2,3,4,0. regWrite=1 only in cycle 5, resultSrc=01. instret goes 0->1.
- sw with memReady low for 3 cycles in MEMWRITE -> memWrite=1 for 4 cycles, then FETCH.
- beq with zero=1 -> pcWrite=1 in BEQ. With zero=0 -> pcWrite=0. Both take 3 cycles.
- jal -> states 0,1,9,7,0. pcWrite=1 in JAL, regWrite=1 in ALUWB, immSrc=11.
- op=1111111:
  - With ILLEGAL_TRAP_EN: state=11, illegal=1, held for 10 cycles.
  - Without it: back to FETCH after DECODE, instret unchanged.
- With CNT_W=4: 16 R-type instructions -> instret wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RV32I datapath.
// Supports lw, sw, R-type, I-type ALU, beq and jal. Memory accesses wait on memReady.
// The block also counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN.
//   Defined:   an unknown opcode traps and stays in TRAP until reset.
//   Undefined: an unknown opcode is skipped.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             adrSrc,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regWrite,
  output logic [1:0]       resultSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       immSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t st, nxt;
  logic   retire;
  logic   pcupdate, branch, irw, rgw, mw;

  // Next-state selection and retire detection.
  always_comb begin
    nxt    = st;
    retire = 1'b0;
    case (st)
      FETCH:    if (memReady) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      nxt = TRAP;
`else
          default:      nxt = FETCH;
`endif
        endcase
      end
      MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (memReady) nxt = MEMWB;
      MEMWB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      MEMWRITE: begin
        if (memReady) begin
          nxt    = FETCH;
          retire = 1'b1;
        end
      end
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      ALUWB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      JAL:      nxt = ALUWB;
      BEQ: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= FETCH;
      instret <= '0;
    end else begin
      st <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // Per-state decode of selects and raw enables.
  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    rgw       = 1'b0;
    mw        = 1'b0;
    adrSrc    = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    case (st)
      FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irw       = memReady;
        pcupdate  = memReady;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD:  adrSrc = 1'b1;
      MEMWB: begin
        resultSrc = 2'b01;
        rgw       = 1'b1;
      end
      MEMWRITE: begin
        adrSrc = 1'b1;
        mw     = 1'b1;
      end
      EXECUTER: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      ALUWB:    rgw = 1'b1;
      JAL: begin
        aluSrcA  = 2'b01;
        aluSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Extender select straight from the opcode.
  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  // Enables are gated by rst_n so that none fire while reset is held,
  // even though FETCH would otherwise follow memReady.
  assign pcWrite  = rst_n & (pcupdate | (branch & zero));
  assign irWrite  = rst_n & irw;
  assign regWrite = rst_n & rgw;
  assign memWrite = rst_n & mw;
`ifdef ILLEGAL_TRAP_EN
  assign illegal  = rst_n & (st == TRAP);
`else
  assign illegal  = 1'b0;
`endif
  assign state    = st;

endmodule
